inst_sram_resp: RTL



---
 rtl/inst_sram_resp.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/inst_sram_resp.sv
// inst_sram_resp: instruction-memory responder for the fetch stage.
// Accepts byte fetch addresses, reads a word array in the accept cycle and
// returns {addr, data, err} in request order after a fixed LATENCY. The
// response path is a LATENCY-stage valid shift register feeding a QDEPTH-entry
// FIFO with write-through. A credit count bounds outstanding requests, so the
// FIFO cannot overflow. flush drops everything outstanding. A word-write port
// preloads the boot image.
// Optional build macro: IMEM_ERR_CHECK_EN. When defined, misaligned or
// out-of-range addresses return err=1 with zero data. When undefined, the index
// is taken from the low address bits, addresses alias, and err is always 0.
//
// Handshake: a request transfers on a cycle with req_valid && req_ready. A
// response transfers on a cycle with resp_valid && resp_ready. resp_* stay
// stable while resp_valid && !resp_ready. Valids never depend combinationally
// on the partner's ready.
module inst_sram_resp #(
  parameter logic [31:0] ADDR_BASE   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter int          QDEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  input  logic                           flush,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_data,
  output logic [31:0]                    resp_addr,
  output logic                           resp_err,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  logic [31:0]                    wr_data
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]   mem [DEPTH_WORDS];

  logic [CW-1:0] count;
  logic          accept;
  logic          pop;

  logic [IW-1:0] rd_idx;
  logic          lookup_err;
  logic [31:0]   rd_word;

  logic [LATENCY-1:0] pv;
  logic [31:0]        pa [LATENCY];
  logic [31:0]        pd [LATENCY];
  logic               pe [LATENCY];

  logic [31:0]   qa [QDEPTH];
  logic [31:0]   qd [QDEPTH];
  logic          qe [QDEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] fcnt;
  logic          fifo_empty;
  logic          fifo_wr;
  logic          fifo_rd;
  logic          last_v;

  // Pointer wrap modulo QDEPTH, so QDEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_ready = (count < CW'(QDEPTH)) && !flush;
  assign accept    = req_valid && req_ready;

`ifdef IMEM_ERR_CHECK_EN
  logic [31:0] byte_off;
  logic [31:0] word_off;
  logic        unused_off_bits;
  assign byte_off        = req_addr - ADDR_BASE;
  assign word_off        = {2'b00, byte_off[31:2]};
  assign rd_idx          = byte_off[IW+1:2];
  assign lookup_err      = (req_addr[1:0] != 2'b00) || (word_off >= 32'(DEPTH_WORDS));
  assign unused_off_bits = ^byte_off[1:0];
`else
  logic unused_addr_bits;
  assign rd_idx           = req_addr[IW+1:2];
  assign lookup_err       = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:IW+2], req_addr[1:0]};
`endif

  // The array is read before the edge, so a same-cycle preload write returns
  // the old word.
  assign rd_word = lookup_err ? 32'h0 : mem[rd_idx];

  // Preload port: plain synchronous word write; the array has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Pipeline valid bits: cleared by reset or flush, otherwise shift one stage per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else if (flush) begin
      pv <= '0;
    end else begin
      pv[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pv[i] <= pv[i-1];
    end
  end

  // Pipeline payload: shifts every cycle; the valid bits say which stages are live.
  always_ff @(posedge clk) begin
    pa[0] <= req_addr;
    pd[0] <= rd_word;
    pe[0] <= lookup_err;
    for (int i = 1; i < LATENCY; i++) begin
      pa[i] <= pa[i-1];
      pd[i] <= pd[i-1];
      pe[i] <= pe[i-1];
    end
  end

  assign last_v     = pv[LATENCY-1];
  assign fifo_empty = (fcnt == '0);
  assign resp_valid = !fifo_empty || last_v;
  assign pop        = resp_valid && resp_ready;
  // The last stage bypasses an empty FIFO. It is stored only if it is not consumed at once.
  assign fifo_wr    = last_v && !(fifo_empty && pop);
  assign fifo_rd    = pop && !fifo_empty;

  // FIFO storage: written from the last pipeline stage.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      qa[wptr] <= pa[LATENCY-1];
      qd[wptr] <= pd[LATENCY-1];
      qe[wptr] <= pe[LATENCY-1];
    end
  end

  // FIFO pointers, FIFO occupancy and credit count; flush clears them all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      fcnt  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      fcnt  <= '0;
      count <= '0;
    end else begin
      if (fifo_wr) wptr <= ptr_inc(wptr);
      if (fifo_rd) rptr <= ptr_inc(rptr);
      case ({fifo_wr, fifo_rd})
        2'b10:   fcnt <= fcnt + CW'(1);
        2'b01:   fcnt <= fcnt - CW'(1);
        default: fcnt <= fcnt;
      endcase
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head-of-queue select. Outputs read zero while nothing is valid.
  always_comb begin
    resp_addr = '0;
    resp_data = '0;
    resp_err  = 1'b0;
    if (!fifo_empty) begin
      resp_addr = qa[rptr];
      resp_data = qd[rptr];
      resp_err  = qe[rptr];
    end else if (last_v) begin
      resp_addr = pa[LATENCY-1];
      resp_data = pd[LATENCY-1];
      resp_err  = pe[LATENCY-1];
    end
  end

endmodule
